mmu_tile_sequencer: RTL
=======================

# mmu_tile_sequencer

Sequences one output-stationary tile computation on the LENGTH×LENGTH systolic matrix multiply array. It takes a start request with a reduction depth K and clears the array's accumulators. It then drives the array enable and the per-lane feed-valid mask across the skewed fill, compute and drain window, and signals completion. It sits between the layer scheduler (start/done handshake) and the array plus its skew/feed buffers.

## Interface
- LENGTH, 256: array dimension (lanes per side); must satisfy 2*LENGTH ≤ 2^KW.
- KW, 16: width of K_LEN.
- PE_LAT, 1: PE register latency added to the drain window.
- CLK  in  1  clock, rising edge.
- ASYNC_RST  in  1  reset; one clock; reset is asynchronous and active-low.
- START  in  1  request a tile; sampled only in IDLE.
- K_LEN  in  KW  reduction depth, latched with START.
- BUF_READY  in  1  feed buffers can supply this step; low = stall.
- ABORT  in  1  cancel the current tile.
- BUSY  out  1  high from the cycle after START acceptance through the DONE cycle.
- DONE  out  1  one-cycle pulse; accumulators hold final results.
- ERR  out  1  one-cycle pulse; START with K_LEN=0 was rejected.
- ARRAY_CLR  out  1  drives the array's synchronous reset.
- ARRAY_EN  out  1  drives the array's enable.
- STEP  out  KW+1  current feed step t.
- LANE_MASK  out  LENGTH  bit r is high when input lane r and weight lane r carry valid data.
- PERF_STALLS  out  32  count of stall cycles (see Configuration).

## Operation
- States: IDLE, CLEAR, FEED, DONE.
- IDLE, START=1, K_LEN≠0: latch K, go to CLEAR.
- IDLE, START=1, K_LEN=0: pulse ERR for 1 cycle, stay in IDLE.
- CLEAR (1 cycle): ARRAY_CLR=1, ARRAY_EN=0, STEP reset to 0. Then go to FEED.
- FEED: T = K + 2*(LENGTH−1) + PE_LAT productive cycles.
  - ARRAY_EN = BUF_READY (combinational).
  - STEP increments only when BUF_READY=1.
  - After the productive cycle with STEP = T−1, go to DONE.
- DONE (1 cycle): DONE=1, ARRAY_EN=0, then return to IDLE. START in DONE is ignored.
- LANE_MASK[r] = ARRAY_EN & (r ≤ STEP < r+K). Compare at KW+2 bits so nothing overflows.
- Outside FEED: LANE_MASK=0, ARRAY_EN=0.
- STEP holds its value through DONE and resets in CLEAR.
- ABORT in CLEAR, FEED or DONE:
  - Next state is IDLE; DONE is not pulsed.
  - ARRAY_CLR=1 for exactly the following cycle, issued from IDLE.
- ABORT in IDLE: START is ignored in that cycle (ABORT wins); no ERR.
- START while BUSY=1: ignored, no queueing.
- Async reset: IDLE, all outputs 0, STEP=0, PERF_STALLS=0. Reset mid-tile abandons the tile with no DONE.

## Timing
- START sampled at edge n → CLEAR in cycle n+1 (BUSY=1, ARRAY_CLR=1).
- With no stalls:
  - FEED occupies cycles n+2 … n+1+T.
  - DONE occurs in cycle n+2+T.
  - IDLE from cycle n+3+T.
- Each BUF_READY=0 cycle in FEED extends FEED by one cycle; ARRAY_EN=0 and LANE_MASK=0 in that cycle.
- ARRAY_CLR, BUSY, DONE, ERR and STEP are registered. ARRAY_EN and LANE_MASK are combinational from state, STEP and BUF_READY.

## Configuration
- MMU_SEQ_PERF_EN defined:
  - PERF_STALLS counts FEED cycles with BUF_READY=0.
  - Counts cumulatively across tiles and saturates at 2^32−1.
  - Cleared only by reset.
- MMU_SEQ_PERF_EN undefined: PERF_STALLS is tied to 0 and the counter is not synthesized.

## Test plan
- LENGTH=4, K_LEN=3, START at cycle 0, BUF_READY=1:
  - ARRAY_CLR high in cycle 1 only.
  - ARRAY_EN high in cycles 2–11 (T=10).
  - DONE in cycle 12; BUSY high in cycles 1–12.
- Same run, LANE_MASK by STEP: 0→0001, 2→0111, 3→1110, 5→1000, 6–9→0000.
- Same run with BUF_READY=0 in cycles 4–5:
  - STEP holds at 2; ARRAY_EN=0 and LANE_MASK=0 in those cycles.
  - DONE moves to cycle 14.
  - PERF_STALLS=2 with MMU_SEQ_PERF_EN defined, 0 without.
- ABORT at STEP=4:
  - Next cycle IDLE with ARRAY_CLR=1, BUSY=0; no DONE.
  - A new START is accepted in the cycle after that.
- START with K_LEN=0: ERR pulses 1 cycle; BUSY stays 0; ARRAY_CLR and ARRAY_EN stay 0.
- Reset asserted in FEED: all outputs 0 immediately. After release, START with K_LEN=1, LENGTH=4 gives T=8 and DONE 10 cycles after START.

Source files
------------

// File: rtl/mmu_tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mmu_tile_sequencer
//  Purpose  : Sequences one output-stationary tile on a LENGTH x LENGTH
//             systolic array: clears the accumulators, drives the array
//             enable and the per-lane feed-valid mask across the skewed
//             fill/compute/drain window, then reports completion.
//  Options  : MMU_SEQ_PERF_EN - when defined, perf_stalls counts FEED
//             cycles with buf_ready low (saturating, cleared by reset
//             only). When undefined, perf_stalls is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module mmu_tile_sequencer #(
  parameter int LENGTH = 256,
  parameter int KW     = 16,
  parameter int PE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic              buf_ready,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              array_clr,
  output logic              array_en,
  output logic [KW:0]       step,
  output logic [LENGTH-1:0] lane_mask,
  output logic [31:0]       perf_stalls
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_clear = 2'd1;
  localparam logic [1:0] c_feed  = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  // Skew fill plus drain plus PE latency, minus one: added to K gives the
  // final productive step index T-1.
  localparam logic [KW+1:0] c_fill = (KW+2)'(2*(LENGTH-1)+PE_LAT-1);

  logic [1:0]    r_state;
  logic [KW-1:0] r_k;
  logic [KW+1:0] r_last;
  logic [KW:0]   r_step;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_clr;
  logic          w_en;
  logic [KW+1:0] w_step_x;
  logic [KW+1:0] w_k_x;

  // Tile control FSM with registered status/strobe outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_k     <= '0;
      r_last  <= '0;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_clr  <= 1'b0;
      case (r_state)
        c_idle: begin
          // abort has priority over a start in the same cycle
          if (start && !abort) begin
            if (k_len == '0) begin
              r_err <= 1'b1;
            end else begin
              r_k     <= k_len;
              r_last  <= {2'b00, k_len} + c_fill;
              r_step  <= '0;
              r_busy  <= 1'b1;
              r_clr   <= 1'b1;
              r_state <= c_clear;
            end
          end
        end
        c_clear: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_clr   <= 1'b1;
            r_state <= c_idle;
          end else begin
            r_state <= c_feed;
          end
        end
        c_feed: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_clr   <= 1'b1;
            r_state <= c_idle;
          end else if (buf_ready) begin
            // Last productive step holds its index through DONE
            if ({1'b0, r_step} == r_last) begin
              r_done  <= 1'b1;
              r_state <= c_done;
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_clr   <= abort;
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign w_en      = (r_state == c_feed) && buf_ready;
  assign w_step_x  = {1'b0, r_step};
  assign w_k_x     = {2'b00, r_k};

  // Lane r carries valid data while r <= step < r + K (skewed feed window)
  for (genvar r = 0; r < LENGTH; r++) begin : g_lane
    localparam logic [KW+1:0] c_lane = (KW+2)'(r);
    assign lane_mask[r] = w_en && (w_step_x >= c_lane) && (w_step_x < (c_lane + w_k_x));
  end

`ifdef MMU_SEQ_PERF_EN
  logic [31:0] r_perf;

  // Saturating count of stalled FEED cycles, cumulative across tiles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if ((r_state == c_feed) && !buf_ready && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_stalls = r_perf;
`else
  assign perf_stalls = '0;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign array_clr = r_clr;
  assign array_en  = w_en;
  assign step      = r_step;

endmodule
`default_nettype wire
